north_buffer_ctrl: RTL and testbench

//  Sequences the weight-stationary NORTH buffer (Kn^T) through its load/reuse cycle. Loads COL_X rows from the LP

---
 rtl/north_buffer_ctrl_pkg.sv | 8 +
 rtl/north_buffer_ctrl_wrap_cnt.sv | 30 +++
 rtl/north_buffer_ctrl.sv | 142 ++++++++++++++
 tb/tb_north_buffer_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/north_buffer_ctrl_pkg.sv
// rtl/north_buffer_ctrl_pkg.sv - shared state encoding and widths for the NORTH buffer controller
package north_buffer_ctrl_pkg;

    typedef enum logic [1:0] {NBC_IDLE, NBC_LOAD, NBC_READ, NBC_DRAIN} nbc_state_t;

    localparam int NBC_STALL_W = 16;

endpackage

// File: rtl/north_buffer_ctrl_wrap_cnt.sv
// rtl/north_buffer_ctrl_wrap_cnt.sv - address counter that wraps to 0 by compare against max
module nbc_wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] r_cnt;

    assign cnt  = r_cnt;
    assign wrap = inc & (r_cnt == max);

    // Compare-based wrap so depths that are not a power of two behave correctly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || wrap) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/north_buffer_ctrl.sv
// rtl/north_buffer_ctrl.sv - NORTH buffer load/reuse sequencer; optional stall counter via NORTH_CTRL_STALL_CNT_EN
module north_buffer_ctrl
    import north_buffer_ctrl_pkg::*;
#(
    parameter  int TOTAL_MODULES = 3,
    parameter  int COL_X         = 16,
    parameter  int NUM_PASSES    = 4,
    parameter  int ADDR_WIDTH    = $clog2(COL_X),
    parameter  int PASS_W        = $clog2(NUM_PASSES + 1),
    localparam int SLICE_W       = $clog2(TOTAL_MODULES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [SLICE_W-1:0]     cfg_slice_idx,
    input  logic                   lp_valid,
    output logic                   lp_ready,
    output logic [SLICE_W-1:0]     n_slicing_idx,
    output logic                   n_wr_en,
    output logic [ADDR_WIDTH-1:0]  n_wr_addr,
    input  logic                   sa_ready,
    output logic                   n_rd_en,
    output logic [ADDR_WIDTH-1:0]  n_rd_addr,
    output logic                   sa_valid,
    output logic                   sa_last,
    output logic [PASS_W-1:0]      pass_idx,
    output logic                   busy,
    output logic                   done,
    output logic [NBC_STALL_W-1:0] stall_cnt
);

    nbc_state_t          r_state, w_next;
    logic [SLICE_W-1:0]  r_slice;
    logic [PASS_W-1:0]   r_pass;
    logic                r_sa_valid, r_sa_last;
    logic                w_wr_wrap, w_rd_wrap, w_last_rd, w_start_acc;

    assign w_start_acc   = start & ~abort & (r_state == NBC_IDLE);
    assign lp_ready      = (r_state == NBC_LOAD);
    assign n_wr_en       = lp_valid & lp_ready;
    assign n_rd_en       = (r_state == NBC_READ) & sa_ready;
    assign w_last_rd     = w_rd_wrap & (r_pass == PASS_W'(NUM_PASSES - 1));
    assign busy          = (r_state != NBC_IDLE);
    assign done          = (r_state == NBC_DRAIN) & ~abort;
    assign sa_valid      = r_sa_valid;
    assign sa_last       = r_sa_last;
    assign pass_idx      = r_pass;
    assign n_slicing_idx = r_slice;

    nbc_wrap_cnt #(.W(ADDR_WIDTH)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (n_wr_en),
        .clr   (abort || (r_state != NBC_LOAD)),
        .max   (ADDR_WIDTH'(COL_X - 1)),
        .cnt   (n_wr_addr),
        .wrap  (w_wr_wrap)
    );

    nbc_wrap_cnt #(.W(ADDR_WIDTH)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (n_rd_en),
        .clr   (abort || (r_state != NBC_READ)),
        .max   (ADDR_WIDTH'(COL_X - 1)),
        .cnt   (n_rd_addr),
        .wrap  (w_rd_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NBC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            NBC_IDLE:  if (start)     w_next = NBC_LOAD;
            NBC_LOAD:  if (w_wr_wrap) w_next = NBC_READ;
            NBC_READ:  if (w_last_rd) w_next = NBC_DRAIN;
            NBC_DRAIN: w_next = NBC_IDLE;
            default:   w_next = NBC_IDLE;
        endcase
        if (abort) w_next = NBC_IDLE;
    end

    // Slice index survives abort; only a new accepted start replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slice <= '0;
        end else if (w_start_acc) begin
            r_slice <= cfg_slice_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= '0;
        end else if (abort || (r_state == NBC_IDLE) || (r_state == NBC_DRAIN)) begin
            r_pass <= '0;
        end else if (w_rd_wrap) begin
            r_pass <= r_pass + PASS_W'(1);
        end
    end

    // One-cycle buffer read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa_valid <= 1'b0;
            r_sa_last  <= 1'b0;
        end else if (abort) begin
            r_sa_valid <= 1'b0;
            r_sa_last  <= 1'b0;
        end else begin
            r_sa_valid <= n_rd_en;
            r_sa_last  <= w_last_rd;
        end
    end

`ifdef NORTH_CTRL_STALL_CNT_EN
    logic [NBC_STALL_W-1:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_start_acc) begin
            r_stall <= '0;
        end else if ((r_state == NBC_READ) && !sa_ready && (r_stall != {NBC_STALL_W{1'b1}})) begin
            r_stall <= r_stall + NBC_STALL_W'(1);
        end
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_north_buffer_ctrl.sv
// tb/tb_north_buffer_ctrl.sv - randomized bench for north_buffer_ctrl against a transaction-count model
module tb_north_buffer_ctrl;

    localparam int TM    = 3;
    localparam int COLX  = 16;
    localparam int NP    = 2;
    localparam int TOTAL = COLX * NP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, lp_valid, sa_ready;
    logic [1:0]  cfg_slice_idx;
    logic        lp_ready, n_wr_en, n_rd_en, sa_valid, sa_last, busy, done;
    logic [1:0]  n_slicing_idx;
    logic [3:0]  n_wr_addr, n_rd_addr;
    logic [1:0]  pass_idx;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 load, 2 read, 3 drain; progress kept as beat counts
    int     m_phase = 0, m_wr = 0, m_rd = 0, m_stall = 0;
    int     m_slice = 0;
    logic   m_pend = 1'b0, m_pend_last = 1'b0;
    int     obs_valid, obs_last, obs_done, obs_stall;

    always #5 clk = ~clk;

    north_buffer_ctrl #(.TOTAL_MODULES(TM), .COL_X(COLX), .NUM_PASSES(NP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_slice_idx (cfg_slice_idx),
        .lp_valid      (lp_valid),
        .lp_ready      (lp_ready),
        .n_slicing_idx (n_slicing_idx),
        .n_wr_en       (n_wr_en),
        .n_wr_addr     (n_wr_addr),
        .sa_ready      (sa_ready),
        .n_rd_en       (n_rd_en),
        .n_rd_addr     (n_rd_addr),
        .sa_valid      (sa_valid),
        .sa_last       (sa_last),
        .pass_idx      (pass_idx),
        .busy          (busy),
        .done          (done),
        .stall_cnt     (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cmp_outputs();
        check_eq("busy",      32'(busy),      32'(m_phase != 0));
        check_eq("lp_ready",  32'(lp_ready),  32'(m_phase == 1));
        check_eq("n_wr_en",   32'(n_wr_en),   32'(m_phase == 1 && lp_valid));
        check_eq("n_wr_addr", 32'(n_wr_addr), (m_phase == 1) ? m_wr : 0);
        check_eq("n_rd_en",   32'(n_rd_en),   32'(m_phase == 2 && sa_ready));
        check_eq("n_rd_addr", 32'(n_rd_addr), (m_phase == 2) ? (m_rd % COLX) : 0);
        if (m_phase == 2 || m_phase == 0)
            check_eq("pass_idx", 32'(pass_idx), (m_phase == 2) ? (m_rd / COLX) : 0);
        check_eq("sa_valid",  32'(sa_valid),  32'(m_pend));
        check_eq("sa_last",   32'(sa_last),   32'(m_pend_last));
        check_eq("done",      32'(done),      32'(m_phase == 3 && !abort));
        check_eq("n_slicing_idx", 32'(n_slicing_idx), m_slice);
`ifdef NORTH_CTRL_STALL_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), m_stall);
`else
        check_eq("stall_cnt", 32'(stall_cnt), 0);
`endif
    endtask

    task automatic step_model();
        logic np = 1'b0, nl = 1'b0;
        if (abort) begin
            m_phase = 0; m_wr = 0; m_rd = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_slice = int'(cfg_slice_idx); m_wr = 0; m_rd = 0; m_stall = 0;
                end
                1: if (lp_valid) begin
                    m_wr++;
                    if (m_wr == COLX) begin m_phase = 2; m_wr = 0; end
                end
                2: if (sa_ready) begin
                    np = 1'b1;
                    nl = (m_rd == TOTAL - 1);
                    m_rd++;
                    if (m_rd == TOTAL) m_phase = 3;
                end else if (m_stall != 16'hFFFF) begin
                    m_stall++;
                end
                default: begin m_phase = 0; m_rd = 0; end
            endcase
        end
        m_pend = np;
        m_pend_last = nl;
    endtask

    task automatic run_cycle();
        #1;
        cmp_outputs();
        if (sa_valid) obs_valid++;
        if (sa_last)  obs_last++;
        if (done) begin obs_done++; obs_stall = int'(stall_cnt); end
        step_model();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; lp_valid = 1'b0; sa_ready = 1'b0;
    endtask

    // lv_mode/sr_mode: 0 held high, 1 patterned, 2 random; abort_at<0 disables abort
    task automatic do_txn(input int lv_mode, input int sr_mode, input logic inj,
                          input logic [1:0] idx, input int abort_at);
        int cyc = 0, rt = 0;
        logic aborted = 1'b0;
        obs_valid = 0; obs_last = 0; obs_done = 0; obs_stall = -1;
        idle_inputs();
        start = 1'b1; cfg_slice_idx = idx;
        run_cycle();
        start = 1'b0;
        while (m_phase != 0 && cyc < 600) begin
            case (lv_mode)
                0:       lp_valid = 1'b1;
                1:       lp_valid = (cyc % 3 == 0);
                default: lp_valid = 1'($urandom % 2);
            endcase
            case (sr_mode)
                0:       sa_ready = 1'b1;
                1:       sa_ready = 1'(rt % 2);
                default: sa_ready = 1'($urandom % 2);
            endcase
            if (m_phase == 2) rt++;
            start = inj && (m_phase == 2) && ($urandom % 4 == 0);
            cfg_slice_idx = 2'($urandom_range(0, TM - 1));
            abort = (abort_at >= 0) && (m_phase == 1) && (m_wr == abort_at);
            if (abort) aborted = 1'b1;
            run_cycle();
            cyc++;
        end
        idle_inputs();
        check_eq("txn_timeout", 32'(cyc < 600), 1);
        if (aborted) begin
            check_eq("abort_no_done",  obs_done, 0);
            check_eq("abort_no_valid", obs_valid, 0);
        end else begin
            check_eq("sa_valid_count", obs_valid, TOTAL);
            check_eq("sa_last_count",  obs_last, 1);
            check_eq("done_count",     obs_done, 1);
`ifdef NORTH_CTRL_STALL_CNT_EN
            if (sr_mode == 1) check_eq("stall_at_done", obs_stall, TOTAL);
`endif
        end
        run_cycle();
        run_cycle();
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        idle_inputs();
        cfg_slice_idx = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        cmp_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle();
        run_cycle();

        do_txn(0, 0, 1'b0, 2'd2, -1);
        do_txn(0, 1, 1'b0, 2'd1, -1);
        do_txn(1, 0, 1'b0, 2'd0, -1);
        do_txn(0, 0, 1'b1, 2'd2, -1);
        do_txn(0, 0, 1'b0, 2'd1, 7);
        do_txn(0, 0, 1'b0, 2'd0, -1);
        for (int i = 0; i < 6; i++)
            do_txn(2, 2, 1'($urandom % 2), 2'($urandom_range(0, TM - 1)), -1);

        // Asynchronous reset in the middle of READ
        start = 1'b1; cfg_slice_idx = 2'd2;
        run_cycle();
        start = 1'b0; lp_valid = 1'b1; sa_ready = 1'b1;
        guard = 0;
        while (!(m_phase == 2 && m_rd == 5) && guard < 100) begin
            run_cycle();
            guard++;
        end
        check_eq("reach_read_timeout", 32'(guard < 100), 1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_busy",     32'(busy), 0);
        check_eq("rst_n_rd_en",  32'(n_rd_en), 0);
        check_eq("rst_rd_addr",  32'(n_rd_addr), 0);
        check_eq("rst_sa_valid", 32'(sa_valid), 0);
        check_eq("rst_pass_idx", 32'(pass_idx), 0);
        check_eq("rst_slice",    32'(n_slicing_idx), 0);
        m_phase = 0; m_wr = 0; m_rd = 0; m_stall = 0; m_slice = 0;
        m_pend = 1'b0; m_pend_last = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        idle_inputs();
        lp_valid = 1'b1; sa_ready = 1'b1;
        repeat (3) run_cycle();
        idle_inputs();
        do_txn(0, 0, 1'b0, 2'd1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
